data_sram_confreg: RTL and testbench



---
 rtl/data_sram_confreg.sv | 152 +++++++++++++++
 tb/tb_data_sram_confreg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_sram_confreg.sv
// Data-side SRAM-bus responder: word RAM plus LED/switch/timer/scratch register bank.
// Define CONFREG_TIMER_IRQ_EN to build the COMPARE/STATUS registers and timer_irq.
module data_sram_confreg #(
  parameter int          RAM_AW    = 14,
  parameter logic [15:0] CONF_BASE = 16'hBFAF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led,
  output logic        timer_irq
);

  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SWITCH  = 16'hF004;
  localparam logic [15:0] OFF_TIMER   = 16'hF008;
  localparam logic [15:0] OFF_COMPARE = 16'hF00C;
  localparam logic [15:0] OFF_STATUS  = 16'hF010;
  localparam logic [15:0] OFF_SCRATCH = 16'hF014;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

  logic [31:0] mem [2**RAM_AW];

  logic              conf_sel, wr_req, reg_we;
  logic [15:0]       offset;
  logic [RAM_AW-1:0] ram_idx;

  logic [31:0] rdata_q, rdata_d, reg_rdata;
  logic [15:0] led_q, led_d;
  logic [15:0] sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] compare_rd, status_rd;

  assign conf_sel = (data_sram_addr[31:16] == CONF_BASE);
  assign offset   = data_sram_addr[15:0];
  assign ram_idx  = data_sram_addr[RAM_AW+1:2];
  assign wr_req   = data_sram_en && (|data_sram_wen);
  assign reg_we   = wr_req && conf_sel;

  // RAM has no reset; only the enabled bytes of the addressed word change
  always_ff @(posedge clk) begin
    if (wr_req && !conf_sel)
      mem[ram_idx] <= merge_bytes(mem[ram_idx], data_sram_wdata, data_sram_wen);
  end

  always_comb begin
    reg_rdata = 32'h0;
    case (offset)
      OFF_LED:     reg_rdata = {16'h0, led_q};
      OFF_SWITCH:  reg_rdata = {16'h0, sw_sync_q};
      OFF_TIMER:   reg_rdata = timer_q;
      OFF_COMPARE: reg_rdata = compare_rd;
      OFF_STATUS:  reg_rdata = status_rd;
      OFF_SCRATCH: reg_rdata = scratch_q;
      default:     reg_rdata = 32'h0;
    endcase
  end

  // Read data is sampled before any same-cycle write lands
  always_comb begin
    rdata_d   = rdata_q;
    led_d     = led_q;
    sw_meta_d = sw_in;
    sw_sync_d = sw_meta_q;
    timer_d   = timer_q + 32'd1;
    scratch_d = scratch_q;
    if (data_sram_en)
      rdata_d = conf_sel ? reg_rdata : mem[ram_idx];
    if (reg_we && offset == OFF_LED) begin
      if (data_sram_wen[0]) led_d[7:0]  = data_sram_wdata[7:0];
      if (data_sram_wen[1]) led_d[15:8] = data_sram_wdata[15:8];
    end
    // A timer write replaces this cycle's increment
    if (reg_we && offset == OFF_TIMER)
      timer_d = merge_bytes(timer_q, data_sram_wdata, data_sram_wen);
    if (reg_we && offset == OFF_SCRATCH)
      scratch_d = merge_bytes(scratch_q, data_sram_wdata, data_sram_wen);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q   <= 32'h0;
      led_q     <= 16'h0;
      sw_meta_q <= 16'h0;
      sw_sync_q <= 16'h0;
      timer_q   <= 32'h0;
      scratch_q <= 32'h0;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      timer_q   <= timer_d;
      scratch_q <= scratch_d;
    end
  end

`ifdef CONFREG_TIMER_IRQ_EN
  logic [31:0] compare_q, compare_d;
  logic        status_q, status_d, match;

  assign match = (timer_q == compare_q);

  // A match in the same cycle as a write-1-clear keeps the flag set
  always_comb begin
    compare_d = compare_q;
    status_d  = status_q;
    if (reg_we && offset == OFF_COMPARE)
      compare_d = merge_bytes(compare_q, data_sram_wdata, data_sram_wen);
    if (reg_we && offset == OFF_STATUS && data_sram_wen[0] && data_sram_wdata[0])
      status_d = 1'b0;
    if (match)
      status_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare_q <= 32'hFFFF_FFFF;
      status_q  <= 1'b0;
    end else begin
      compare_q <= compare_d;
      status_q  <= status_d;
    end
  end

  assign compare_rd = compare_q;
  assign status_rd  = {31'h0, status_q};
  assign timer_irq  = status_q;
`else
  assign compare_rd = 32'h0;
  assign status_rd  = 32'h0;
  assign timer_irq  = 1'b0;
`endif

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;

endmodule

// File: tb/tb_data_sram_confreg.sv
// Directed self-checking bench for data_sram_confreg: RAM, register map, switch sync,
// timer wrap, match/irq (both builds of CONFREG_TIMER_IRQ_EN) and async reset.
module tb_data_sram_confreg;

  localparam logic [31:0] A_LED     = 32'hBFAF_F000;
  localparam logic [31:0] A_SWITCH  = 32'hBFAF_F004;
  localparam logic [31:0] A_TIMER   = 32'hBFAF_F008;
  localparam logic [31:0] A_COMPARE = 32'hBFAF_F00C;
  localparam logic [31:0] A_STATUS  = 32'hBFAF_F010;
  localparam logic [31:0] A_SCRATCH = 32'hBFAF_F014;
  localparam logic [31:0] A_UNDEF   = 32'hBFAF_F0FC;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] sw_in;
  logic [15:0] led;
  logic        timer_irq;

  int assertCount = 0;
  int failCount   = 0;
  int riseCycle;
  logic sawIrq;

  data_sram_confreg dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .sw_in           (sw_in),
    .led             (led),
    .timer_irq       (timer_irq)
  );

  always #5 clk = ~clk;

  // Drives one bus cycle starting at a falling edge and returns at the next falling edge
  task automatic applyStimulus(input logic en, input logic [3:0] wen,
                               input logic [31:0] addr, input logic [31:0] wdata);
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    data_sram_en = 1'b0;
    data_sram_wen = 4'h0;
    data_sram_addr = 32'h0;
    data_sram_wdata = 32'h0;
    sw_in = 16'h0;
    #1;
    checkOutput("reset_rdata", data_sram_rdata, 32'h0);
    checkOutput("reset_led", {16'h0, led}, 32'h0);
    checkOutput("reset_irq", {31'h0, timer_irq}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // RAM byte-merge and read latency
    applyStimulus(1'b1, 4'hF, 32'h0000_0100, 32'h1234_5678);
    applyStimulus(1'b1, 4'b0010, 32'h0000_0100, 32'hAABB_CCDD);
    checkOutput("ram_read_before_write", data_sram_rdata, 32'h1234_5678);
    applyStimulus(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    checkOutput("ram_merged_read", data_sram_rdata, 32'h1234_CC78);
    applyStimulus(1'b1, 4'h0, 32'h0001_0100, 32'h0);
    checkOutput("ram_alias_read", data_sram_rdata, 32'h1234_CC78);
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("idle_holds_rdata", data_sram_rdata, 32'h1234_CC78);

    // LED, undefined offset, scratch
    applyStimulus(1'b1, 4'hF, A_LED, 32'h0003_00A5);
    checkOutput("led_out", {16'h0, led}, 32'h0000_00A5);
    applyStimulus(1'b1, 4'h0, A_LED, 32'h0);
    checkOutput("led_read", data_sram_rdata, 32'h0000_00A5);
    applyStimulus(1'b1, 4'b0010, A_LED, 32'h0000_1100);
    checkOutput("led_byte_write", {16'h0, led}, 32'h0000_11A5);
    applyStimulus(1'b1, 4'hF, A_UNDEF, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 4'h0, A_UNDEF, 32'h0);
    checkOutput("undef_read", data_sram_rdata, 32'h0);
    applyStimulus(1'b1, 4'hF, A_SCRATCH, 32'hCAFE_F00D);
    applyStimulus(1'b1, 4'b1000, A_SCRATCH, 32'h5A00_0000);
    applyStimulus(1'b1, 4'h0, A_SCRATCH, 32'h0);
    checkOutput("scratch_merge", data_sram_rdata, 32'h5AFE_F00D);

    // Switch synchroniser: read one cycle after the change sees the old value
    sw_in = 16'h8001;
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 4'h0, A_SWITCH, 32'h0);
    checkOutput("switch_early", data_sram_rdata, 32'h0);
    applyStimulus(1'b1, 4'h0, A_SWITCH, 32'h0);
    checkOutput("switch_synced", data_sram_rdata, 32'h0000_8001);
    applyStimulus(1'b1, 4'hF, A_SWITCH, 32'h1234_5678);
    applyStimulus(1'b1, 4'h0, A_SWITCH, 32'h0);
    checkOutput("switch_ro", data_sram_rdata, 32'h0000_8001);

    // Timer write then wrap
    applyStimulus(1'b1, 4'hF, A_TIMER, 32'hFFFF_FFFE);
    applyStimulus(1'b1, 4'h0, A_TIMER, 32'h0);
    checkOutput("timer_0", data_sram_rdata, 32'hFFFF_FFFE);
    applyStimulus(1'b1, 4'h0, A_TIMER, 32'h0);
    checkOutput("timer_1", data_sram_rdata, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 4'h0, A_TIMER, 32'h0);
    checkOutput("timer_wrap", data_sram_rdata, 32'h0);

`ifdef CONFREG_TIMER_IRQ_EN
    applyStimulus(1'b1, 4'hF, A_COMPARE, 32'h0000_0020);
    applyStimulus(1'b1, 4'hF, A_STATUS, 32'h1);
    checkOutput("irq_cleared_pre", {31'h0, timer_irq}, 32'h0);
    applyStimulus(1'b1, 4'hF, A_TIMER, 32'h0000_0010);
    riseCycle = 0;
    for (int i = 1; i <= 40 && riseCycle == 0; i++) begin
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      if (timer_irq) riseCycle = i;
    end
    checkOutput("irq_rise_delay", riseCycle, 32'd17);
    applyStimulus(1'b1, 4'h0, A_STATUS, 32'h0);
    checkOutput("status_read", data_sram_rdata, 32'h1);
    applyStimulus(1'b1, 4'h0, A_COMPARE, 32'h0);
    checkOutput("compare_read", data_sram_rdata, 32'h0000_0020);
    applyStimulus(1'b1, 4'hF, A_STATUS, 32'h1);
    checkOutput("irq_w1c", {31'h0, timer_irq}, 32'h0);
    applyStimulus(1'b1, 4'hF, A_TIMER, 32'h0000_001E);
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 4'hF, A_STATUS, 32'h1);
    checkOutput("irq_set_wins", {31'h0, timer_irq}, 32'h1);
    applyStimulus(1'b1, 4'hF, A_STATUS, 32'h1);
    checkOutput("irq_w1c_again", {31'h0, timer_irq}, 32'h0);
`else
    applyStimulus(1'b1, 4'hF, A_COMPARE, 32'h0000_0020);
    applyStimulus(1'b1, 4'h0, A_COMPARE, 32'h0);
    checkOutput("compare_absent", data_sram_rdata, 32'h0);
    applyStimulus(1'b1, 4'hF, A_TIMER, 32'h0000_0010);
    sawIrq = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      if (timer_irq) sawIrq = 1'b1;
    end
    checkOutput("irq_tied_low", {31'h0, sawIrq}, 32'h0);
    applyStimulus(1'b1, 4'h0, A_STATUS, 32'h0);
    checkOutput("status_absent", data_sram_rdata, 32'h0);
`endif

    // Asynchronous reset in the middle of a read burst
    applyStimulus(1'b1, 4'h0, A_LED, 32'h0);
    applyStimulus(1'b1, 4'h0, A_LED, 32'h0);
    checkOutput("burst_led_read", data_sram_rdata, 32'h0000_11A5);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_rdata", data_sram_rdata, 32'h0);
    checkOutput("async_rst_led", {16'h0, led}, 32'h0);
    checkOutput("async_rst_irq", {31'h0, timer_irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 4'h0, A_TIMER, 32'h0);
    checkOutput("timer_after_rst", data_sram_rdata, 32'h0);
    applyStimulus(1'b1, 4'h0, A_TIMER, 32'h0);
    checkOutput("timer_counts_after_rst", data_sram_rdata, 32'h1);
    applyStimulus(1'b1, 4'h0, A_COMPARE, 32'h0);
`ifdef CONFREG_TIMER_IRQ_EN
    checkOutput("compare_after_rst", data_sram_rdata, 32'hFFFF_FFFF);
`else
    checkOutput("compare_after_rst", data_sram_rdata, 32'h0);
`endif
    applyStimulus(1'b1, 4'h0, A_SCRATCH, 32'h0);
    checkOutput("scratch_after_rst", data_sram_rdata, 32'h0);
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
